// File: rtl/dsa_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and derived sizes.
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_e;

    // Number of digits needed to cover the operand width.
    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Digit counter width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder_slice.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module digit_adder_slice #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin computed DIGIT bits per clock with a
// start/done handshake, registered sum, carry-out and signed overflow.
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_w(NDIG);

    generate
        if ((DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    dsa_state_e       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_reg;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_cmsb;
    logic [WIDTH-1:0] full;

    digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x     (a_sh[DIGIT-1:0]),
        .y     (b_sh[DIGIT-1:0]),
        .ci    (carry_reg),
        .s     (d_s),
        .co    (d_co),
        .c_msb (d_cmsb)
    );

    // Partial-sum shifter holds completed digits; the last digit joins it directly.
    generate
        if (NDIG > 1) begin : g_multi
            logic [WIDTH-DIGIT-1:0] part;

            assign full = {d_s, part};

            always_ff @(posedge clk) begin
                if (rst) begin
                    part <= '0;
                end else if (state == RUN) begin
                    part <= full[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_single
            assign full = d_s;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_reg <= cin;
                        cnt       <= '0;
                        state     <= RUN;
                    end else begin
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    a_sh      <= a_sh >> DIGIT;
                    b_sh      <= b_sh >> DIGIT;
                    carry_reg <= d_co;
                    cnt       <= cnt + CW'(1);
                    if (cnt == CW'(NDIG - 1)) begin
                        sum      <= full;
                        cout     <= d_co;
                        overflow <= d_cmsb ^ d_co;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: four adder configurations against an arithmetic reference.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        cin;
    logic        st4, st1, st16, st42;
    logic [3:0]  a42, b42;
    logic        cin42;

    logic        rdy4, bsy4, dn4, co4, ov4;
    logic [15:0] sum4;
    logic        rdy1, bsy1, dn1, co1, ov1;
    logic [15:0] sum1;
    logic        rdy16, bsy16, dn16, co16, ov16;
    logic [15:0] sum16;
    logic        rdy42, bsy42, dn42, co42, ov42;
    logic [3:0]  sum42;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .a(a), .b(b), .cin(cin),
        .ready(rdy4), .busy(bsy4), .done(dn4), .sum(sum4), .cout(co4), .overflow(ov4));

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .a(a), .b(b), .cin(cin),
        .ready(rdy1), .busy(bsy1), .done(dn1), .sum(sum1), .cout(co1), .overflow(ov1));

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(st16), .a(a), .b(b), .cin(cin),
        .ready(rdy16), .busy(bsy16), .done(dn16), .sum(sum16), .cout(co16), .overflow(ov16));

    digit_serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut42 (
        .clk(clk), .rst(rst), .start(st42), .a(a42), .b(b42), .cin(cin42),
        .ready(rdy42), .busy(bsy42), .done(dn42), .sum(sum42), .cout(co42), .overflow(ov42));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {cout, overflow, sum}.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic        ovf;
        t   = {1'b0, x} + {1'b0, y} + 17'(c);
        ovf = (x[15] == y[15]) && (t[15] != x[15]);
        return {t[16], ovf, t[15:0]};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int t;
        logic ovf;
        t   = int'(x) + int'(y) + int'(c);
        ovf = (x[3] == y[3]) && (t[3] != x[3]);
        return {t[4], ovf, 4'(t)};
    endfunction

    // One operation on the three 16-bit instances in parallel, checking results and latency.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input string tag);
        logic [17:0] exp;
        int lat4, lat1, lat16, busy_cnt;
        exp = model16(ta, tb, tc);
        lat4 = 0; lat1 = 0; lat16 = 0; busy_cnt = 0;
        @(negedge clk);
        a = ta; b = tb; cin = tc;
        st4 = 1'b1; st1 = 1'b1; st16 = 1'b1;
        @(posedge clk);
        #1;
        st4 = 1'b0; st1 = 1'b0; st16 = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        if (bsy4) busy_cnt++;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bsy4) busy_cnt++;
            if (dn4 && lat4 == 0) begin
                lat4 = e;
                check({tag, " res d4"}, 32'({co4, ov4, sum4}), 32'(exp));
            end
            if (dn1 && lat1 == 0) begin
                lat1 = e;
                check({tag, " res d1"}, 32'({co1, ov1, sum1}), 32'(exp));
            end
            if (dn16 && lat16 == 0) begin
                lat16 = e;
                check({tag, " res d16"}, 32'({co16, ov16, sum16}), 32'(exp));
            end
            if (lat4 != 0 && lat1 != 0 && lat16 != 0) break;
        end
        check({tag, " lat d4"}, 32'(lat4), 32'd4);
        check({tag, " busy d4"}, 32'(busy_cnt), 32'd4);
        check({tag, " lat d1"}, 32'(lat1), 32'd16);
        check({tag, " lat d16"}, 32'(lat16), 32'd1);
    endtask

    initial begin
        logic [17:0] exp1, exp2;
        int t1, t2, stable, ndone;

        rst = 1'b1; st4 = 1'b0; st1 = 1'b0; st16 = 1'b0; st42 = 1'b0;
        a = '0; b = '0; cin = 1'b0; a42 = '0; b42 = '0; cin42 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset state", 32'({rdy4, bsy4, dn4, co4, ov4, sum4}), 32'({1'b1, 4'b0, 16'h0}));

        run16(16'h0000, 16'h0000, 1'b0, "zero");
        run16(16'hFFFF, 16'h0001, 1'b0, "ripple");
        run16(16'h1234, 16'h4321, 1'b1, "cin");
        run16(16'h7FFF, 16'h0001, 1'b0, "posovf");
        run16(16'h8000, 16'h8000, 1'b0, "negovf");
        run16(16'hFFFF, 16'hFFFF, 1'b1, "allones");

        // Start held high through RUN with junk operands, then a back-to-back accept.
        exp1 = model16(16'h1234, 16'h4321, 1'b1);
        exp2 = model16(16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; st4 = 1'b1;
        @(posedge clk);
        #1;
        t1 = 0;
        for (int e = 1; e <= 20; e++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(posedge clk);
            #1;
            if (dn4) begin
                t1 = e;
                break;
            end
        end
        check("hs lat1", 32'(t1), 32'd4);
        check("hs res1", 32'({co4, ov4, sum4}), 32'(exp1));
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
        @(posedge clk);
        #1;
        st4 = 1'b0;
        t2 = 0; stable = 1;
        for (int e = 1; e <= 20; e++) begin
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk);
            #1;
            if (dn4) begin
                t2 = e;
                break;
            end
            if ({co4, ov4, sum4} !== exp1) stable = 0;
        end
        check("hs gap", 32'(t2 + 1), 32'd5);
        check("hs stable", 32'(stable), 32'd1);
        check("hs res2", 32'({co4, ov4, sum4}), 32'(exp2));

        // Abort in the second RUN cycle.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h1111; cin = 1'b0; st4 = 1'b1;
        @(posedge clk);
        #1;
        st4 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort state", 32'({rdy4, bsy4, dn4, co4, ov4, sum4}), 32'({1'b1, 4'b0, 16'h0}));
        ndone = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            if (dn4) ndone++;
        end
        check("abort nodone", 32'(ndone), 32'd0);
        run16(16'h00FF, 16'h0001, 1'b0, "postrst");

        for (int i = 0; i < 20; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), "rand");
        end

        // Exhaustive 4-bit / 2-digit configuration.
        for (int i = 0; i < 512; i++) begin
            logic [5:0] e4;
            int lat;
            e4 = model4(4'(i), 4'(i >> 4), 1'(i >> 8));
            @(negedge clk);
            a42 = 4'(i); b42 = 4'(i >> 4); cin42 = 1'(i >> 8); st42 = 1'b1;
            @(posedge clk);
            #1;
            st42 = 1'b0;
            a42 = 4'($urandom); b42 = 4'($urandom);
            lat = 0;
            for (int e = 1; e <= 6; e++) begin
                @(posedge clk);
                #1;
                if (dn42) begin
                    lat = e;
                    break;
                end
            end
            check($sformatf("exh4 %0d", i), 32'({lat[3:0], co42, ov42, sum42}), 32'({4'd2, e4}));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
